if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch unit for the 64-bit pipeline. It owns the PC, issues one-at-a-time requests to instruction memory over a req/ready + rvalid handshake, and presents `current_pc`/`inst` with a `waiting` flag to the IF/ID pipeline register. It obeys the same `stall` and `jb` controls the IF/ID register uses, and redirects to `jb_pc` on a taken jump or branch. Responses from requests that a redirect has made stale are discarded.

## Interface
- `RESET_PC`, 64'd0, first fetch address after reset
- `NOP`, 32'h0000_0013, instruction value presented when no valid fetch is held (`addi x0,x0,0`)
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-low reset (`rst`=0 resets on the edge)
- `stall`  in  1  hazard stall; the held instruction is not consumed
- `jb`  in  1  taken jump/branch redirect, one-cycle pulse
- `jb_pc`  in  64  redirect target
- `imem_req`  out  1  fetch request valid
- `imem_addr`  out  64  fetch address, bits [1:0] always 0
- `imem_ready`  in  1  memory accepts the request this cycle when `imem_req`=1
- `imem_rvalid`  in  1  read data valid, earliest 1 cycle after acceptance
- `imem_rdata`  in  32  instruction word
- `current_pc`  out  64  PC of the presented instruction
- `inst`  out  32  presented instruction
- `waiting`  out  1  1 = no valid instruction presented; downstream holds

## Operation
- Registers:
  - `pc`: next fetch address.
  - `state`: one of IDLE, REQ, RESP, VALID.
  - `drop`: discard the next response.
  - `pc_buf`, `inst_buf`: captured fetch.
- Outputs by state:
  - `imem_req` = (state==REQ).
  - `imem_addr` = {pc[63:2],2'b00}.
  - `waiting` = (state!=VALID).
  - `current_pc`/`inst` = `pc_buf`/`inst_buf` in VALID. Otherwise `pc_buf`/`NOP`.
- Reset (`rst`=0 at the edge): state=IDLE, `pc`=RESET_PC, `drop`=0, `pc_buf`=0, `inst_buf`=NOP.
  - IDLE outputs: `imem_req`=0, `waiting`=1, `inst`=NOP, `current_pc`=0.
  - Reset takes precedence over every other input in every state.
- IDLE → REQ unconditionally on the first edge with `rst`=1.
- REQ:
  - `imem_ready`=1 → RESP. If `jb`=1 in the same cycle, also `drop`<=1 and `pc`<=`jb_pc`.
  - `imem_ready`=0 with `jb`=1 → `pc`<=`jb_pc`, stay in REQ. The new address appears next cycle.
  - `imem_rvalid` is ignored in REQ.
- RESP:
  - `jb`=1 → `pc`<=`jb_pc`. Then:
    - If `imem_rvalid`=1 that cycle → discard the response, `drop`<=0, go to REQ.
    - Else → `drop`<=1, stay in RESP.
  - `jb`=0, `imem_rvalid`=1, `drop`=1 → discard, `drop`<=0, go to REQ.
  - `jb`=0, `imem_rvalid`=1, `drop`=0 → `inst_buf`<=`imem_rdata`, `pc_buf`<=`pc`, go to VALID.
- VALID:
  - `jb`=1 → `pc`<=`jb_pc`, go to REQ. `jb` has priority over `stall`.
  - `stall`=1 → hold all registers.
  - Otherwise the instruction is consumed: `pc`<=`pc`+4, go to REQ.
- Arithmetic: `pc`+4 is 64-bit and wraps modulo 2^64 (0xFFFF_FFFF_FFFF_FFFC → 0). `jb_pc[1:0]` is stored but masked on `imem_addr`.
- `stall` has no effect outside VALID. A redirect is never lost in any non-IDLE state. At most one request is outstanding.

## Timing
- Request accepted at edge N. `imem_rvalid` arrives at cycle N+k (k≥1). Instruction is presented with `waiting`=0 in cycle N+k+1.
- Minimum 3 cycles per instruction (REQ, RESP, VALID) with zero-wait memory.
- The VALID→REQ edge coincides with the IF/ID register capturing `inst`. `waiting` rises in the cycle after consumption.
- After a `jb` pulse at cycle J, the first request to `jb_pc` appears:
  - at J+1 when no response is outstanding;
  - otherwise in the cycle after the stale response is dropped.
- After `rst` returns to 1: the first `imem_req` is high at the 2nd edge after release (IDLE → REQ).

## Test plan
- Reset then zero-wait memory (ready=1, rvalid 1 cycle after acceptance), no stall/jb:
  - `imem_addr` sequence is 0, 4, 8.
  - `inst` equals each word with `waiting`=0 every 3rd cycle.
  - `waiting`=1 and `inst`=0x13 during reset.
- `stall` held 4 cycles in VALID with PC 0x8:
  - `inst`/`current_pc` are stable for 4 cycles and no request is issued.
  - The next `imem_addr` is 0xC.
- `jb`=1 with `jb_pc`=0x100 in RESP, rvalid 2 cycles later:
  - The stale response is not presented (`waiting` stays 1).
  - The next request address is 0x100.
- `jb`=1 in the same cycle as `imem_rvalid` in RESP:
  - The data is discarded.
  - The request to `jb_pc` is issued the next cycle.
- `jb` and `stall` both 1 in VALID, `jb_pc`=0x40: the next `imem_addr` is 0x40.
- Wrap and reset:
  - `RESET_PC`=0xFFFF_FFFF_FFFF_FFFC: the second fetch address is 0.
  - `rst`=0 asserted while in RESP: the block returns to IDLE with outputs at reset values, and the late `imem_rvalid` is ignored.

Source files
------------

// File: rtl/if_fetch.sv
//==============================================================================
// if_fetch : instruction-fetch unit, owns the PC and a one-deep imem handshake
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module if_fetch #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jb,
  input  logic [63:0] jb_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [63:0] current_pc,
  output logic [31:0] inst,
  output logic        waiting
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;
  localparam logic [1:0] S_VALID = 2'd3;

  logic [1:0]  r_state;
  logic [63:0] r_pc;
  logic        r_drop;
  logic [63:0] r_pc_buf;
  logic [31:0] r_inst_buf;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_drop     <= 1'b0;
      r_pc_buf   <= 64'd0;
      r_inst_buf <= NOP;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_REQ;

        S_REQ: begin
          if (imem_ready) begin
            r_state <= S_RESP;
            if (jb) begin
              r_drop <= 1'b1;
              r_pc   <= jb_pc;
            end
          end else if (jb) begin
            r_pc <= jb_pc;
          end
        end

        S_RESP: begin
          // A redirect while a response is in flight marks that response stale.
          if (jb) begin
            r_pc <= jb_pc;
            if (imem_rvalid) begin
              r_drop  <= 1'b0;
              r_state <= S_REQ;
            end else begin
              r_drop <= 1'b1;
            end
          end else if (imem_rvalid) begin
            if (r_drop) begin
              r_drop  <= 1'b0;
              r_state <= S_REQ;
            end else begin
              r_inst_buf <= imem_rdata;
              r_pc_buf   <= r_pc;
              r_state    <= S_VALID;
            end
          end
        end

        S_VALID: begin
          if (jb) begin
            r_pc    <= jb_pc;
            r_state <= S_REQ;
          end else if (!stall) begin
            r_pc    <= r_pc + 64'd4;
            r_state <= S_REQ;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  logic w_valid;
  assign w_valid    = (r_state == S_VALID);
  assign imem_req   = (r_state == S_REQ);
  assign imem_addr  = {r_pc[63:2], 2'b00};
  assign waiting    = !w_valid;
  assign current_pc = r_pc_buf;
  assign inst       = w_valid ? r_inst_buf : NOP;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch.sv
// Directed self-checking bench for if_fetch; a second instance covers PC wrap.
`default_nettype none

module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst, stall, jb, imem_ready, imem_rvalid;
  logic [63:0] jb_pc;
  logic [31:0] imem_rdata;
  logic        imem_req, waiting;
  logic [63:0] imem_addr, current_pc;
  logic [31:0] inst;

  logic        rst_w, ready_w, rvalid_w;
  logic [31:0] rdata_w;
  logic        req_w, waiting_w;
  logic [63:0] addr_w, cpc_w;
  logic [31:0] inst_w;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  if_fetch u_dut (
    .clk(clk), .rst(rst), .stall(stall), .jb(jb), .jb_pc(jb_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .current_pc(current_pc), .inst(inst), .waiting(waiting)
  );

  if_fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst_w), .stall(1'b0), .jb(1'b0), .jb_pc(64'd0),
    .imem_req(req_w), .imem_addr(addr_w), .imem_ready(ready_w),
    .imem_rvalid(rvalid_w), .imem_rdata(rdata_w),
    .current_pc(cpc_w), .inst(inst_w), .waiting(waiting_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; jb = 1'b0; jb_pc = 64'd0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    rst_w = 1'b0; ready_w = 1'b1; rvalid_w = 1'b0; rdata_w = 32'd0;

    // Reset, with memory inputs active to show they are ignored
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_0000;
    tick();
    chk("rst_waiting", waiting, 1);
    chk("rst_inst", inst, 64'h13);
    chk("rst_req", imem_req, 0);
    chk("rst_pc", current_pc, 0);
    imem_rvalid = 1'b0;
    rst = 1'b1;

    // Zero-wait memory: 0, 4, 8
    tick();
    chk("f0_req", imem_req, 1);
    chk("f0_addr", imem_addr, 64'h0);
    chk("f0_wait", waiting, 1);
    tick();
    chk("f0_resp_req", imem_req, 0);
    imem_rvalid = 1'b1; imem_rdata = 32'h1111_0001;
    tick();
    chk("f0_wait_lo", waiting, 0);
    chk("f0_inst", inst, 64'h1111_0001);
    chk("f0_cpc", current_pc, 64'h0);
    imem_rvalid = 1'b0;
    tick();
    chk("f1_req", imem_req, 1);
    chk("f1_addr", imem_addr, 64'h4);
    chk("f1_wait", waiting, 1);
    chk("f1_inst_nop", inst, 64'h13);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h2222_0002;
    tick();
    chk("f1_inst", inst, 64'h2222_0002);
    chk("f1_cpc", current_pc, 64'h4);
    imem_rvalid = 1'b0;
    tick();
    chk("f2_addr", imem_addr, 64'h8);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h3333_0003;
    tick();
    chk("f2_inst", inst, 64'h3333_0003);
    imem_rvalid = 1'b0;

    // Stall held four cycles in VALID
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_wait", waiting, 0);
      chk("stall_inst", inst, 64'h3333_0003);
      chk("stall_cpc", current_pc, 64'h8);
      chk("stall_req", imem_req, 0);
    end
    stall = 1'b0;
    tick();
    chk("post_stall_req", imem_req, 1);
    chk("post_stall_addr", imem_addr, 64'hC);

    // Redirect in RESP with the stale response two cycles later
    tick();
    jb = 1'b1; jb_pc = 64'h100;
    tick();
    jb = 1'b0;
    chk("jbresp_wait0", waiting, 1);
    chk("jbresp_req0", imem_req, 0);
    tick();
    chk("jbresp_wait1", waiting, 1);
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0001;
    tick();
    imem_rvalid = 1'b0;
    chk("jbresp_wait2", waiting, 1);
    chk("jbresp_req", imem_req, 1);
    chk("jbresp_addr", imem_addr, 64'h100);

    // Redirect coinciding with rvalid in RESP
    tick();
    jb = 1'b1; jb_pc = 64'h200;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0002;
    tick();
    jb = 1'b0; imem_rvalid = 1'b0;
    chk("jbrv_wait", waiting, 1);
    chk("jbrv_req", imem_req, 1);
    chk("jbrv_addr", imem_addr, 64'h200);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h4444_0004;
    tick();
    imem_rvalid = 1'b0;
    chk("jbrv_inst", inst, 64'h4444_0004);
    chk("jbrv_cpc", current_pc, 64'h200);

    // jb beats stall in VALID; low target bits masked on the address
    jb = 1'b1; stall = 1'b1; jb_pc = 64'h43;
    tick();
    jb = 1'b0; stall = 1'b0;
    chk("jbstall_req", imem_req, 1);
    chk("jbstall_addr", imem_addr, 64'h40);
    chk("jbstall_wait", waiting, 1);

    // Reset asserted in RESP, late rvalid afterwards
    tick();
    chk("rresp_req", imem_req, 0);
    rst = 1'b0;
    tick();
    chk("rresp_req0", imem_req, 0);
    chk("rresp_wait", waiting, 1);
    chk("rresp_inst", inst, 64'h13);
    chk("rresp_cpc", current_pc, 0);
    rst = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0003;
    tick();
    chk("late_req", imem_req, 1);
    chk("late_addr", imem_addr, 64'h0);
    chk("late_wait", waiting, 1);

    // REQ with ready low: rvalid ignored, redirect re-targets the request
    imem_ready = 1'b0; jb = 1'b1; jb_pc = 64'h80;
    tick();
    jb = 1'b0; imem_rvalid = 1'b0;
    chk("rdy0_wait", waiting, 1);
    chk("rdy0_req", imem_req, 1);
    chk("rdy0_addr", imem_addr, 64'h80);

    // PC wrap on the second instance
    rst_w = 1'b1;
    tick();
    chk("wrap_req0", req_w, 1);
    chk("wrap_addr0", addr_w, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    rvalid_w = 1'b1; rdata_w = 32'h5555_0005;
    tick();
    rvalid_w = 1'b0;
    chk("wrap_inst", inst_w, 64'h5555_0005);
    chk("wrap_cpc", cpc_w, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    chk("wrap_req1", req_w, 1);
    chk("wrap_addr1", addr_w, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
